// File: rtl/locked_regbank_arbiter_if.sv
// Bus bundle between the two write requesters, the read port and the
// lockable register bank arbiter.
interface locked_regbank_arbiter_if #(
    parameter int NREGS = 4,
    parameter int AW    = 2,
    parameter int DW    = 16
);
    logic             host_req;
    logic [AW-1:0]    host_addr;
    logic [DW-1:0]    host_wdata;
    logic             host_lock;
    logic             host_ack;
    logic             host_err;

    logic             dbg_req;
    logic [AW-1:0]    dbg_addr;
    logic [DW-1:0]    dbg_wdata;
    logic             dbg_ack;
    logic             dbg_err;

    logic             trusted;
    logic             debug_mode;

    logic [AW-1:0]    rd_addr;
    logic [DW-1:0]    rd_data;
    logic [NREGS-1:0] lock_vec;
    logic [7:0]       deny_cnt;

    modport master (
        output host_req, host_addr, host_wdata, host_lock,
        output dbg_req, dbg_addr, dbg_wdata,
        output trusted, debug_mode, rd_addr,
        input  host_ack, host_err, dbg_ack, dbg_err,
        input  rd_data, lock_vec, deny_cnt
    );

    modport slave (
        input  host_req, host_addr, host_wdata, host_lock,
        input  dbg_req, dbg_addr, dbg_wdata,
        input  trusted, debug_mode, rd_addr,
        output host_ack, host_err, dbg_ack, dbg_err,
        output rd_data, lock_vec, deny_cnt
    );
endinterface

// File: rtl/locked_regbank_arbiter.sv
// Round-robin write arbiter for a bank of sticky-lockable registers shared by
// a host port and a debug port, with a saturating denial counter.
module locked_regbank_arbiter #(
    parameter int NREGS = 4,
    parameter int AW    = 2,
    parameter int DW    = 16
) (
    input logic                      clk,
    input logic                      reset,
    locked_regbank_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    localparam logic [AW:0] NREGS_L = (AW+1)'(NREGS);

    logic [1:0]       state;
    logic             last_dbg;
    logic             grant_dbg;
    logic [AW-1:0]    lat_addr;
    logic [DW-1:0]    lat_wdata;
    logic             lat_lock;
    logic             permit;
    logic [NREGS-1:0] lock;
    logic [7:0]       deny;
    logic [DW-1:0]    regs [NREGS];

    logic pick_dbg;
    logic lat_in_range;
    logic rd_in_range;

    // Debug wins only when host is idle or host was served last.
    assign pick_dbg     = bus.dbg_req && (!bus.host_req || !last_dbg);
    assign lat_in_range = ({1'b0, lat_addr} < NREGS_L);
    assign rd_in_range  = ({1'b0, bus.rd_addr} < NREGS_L);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_dbg  <= 1'b1;
            grant_dbg <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_lock  <= 1'b0;
            permit    <= 1'b0;
            lock      <= '0;
            deny      <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.host_req || bus.dbg_req) begin
                        grant_dbg <= pick_dbg;
                        last_dbg  <= pick_dbg;
                        lat_addr  <= pick_dbg ? bus.dbg_addr  : bus.host_addr;
                        lat_wdata <= pick_dbg ? bus.dbg_wdata : bus.host_wdata;
                        lat_lock  <= !pick_dbg && bus.host_lock;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    // Debug bypasses the lock but needs both authorisation inputs.
                    if (grant_dbg) begin
                        permit <= lat_in_range && bus.trusted && bus.debug_mode;
                    end else begin
                        permit <= lat_in_range && !lock[lat_addr];
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (permit) begin
                        regs[lat_addr] <= lat_wdata;
                        if (lat_lock) begin
                            lock[lat_addr] <= 1'b1;
                        end
                    end else if (deny != 8'hFF) begin
                        deny <= deny + 8'd1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rd_data <= '0;
        end else begin
            bus.rd_data <= rd_in_range ? regs[bus.rd_addr] : '0;
        end
    end

    assign bus.host_ack = (state == RESP) && !grant_dbg;
    assign bus.host_err = (state == RESP) && !grant_dbg && !permit;
    assign bus.dbg_ack  = (state == RESP) && grant_dbg;
    assign bus.dbg_err  = (state == RESP) && grant_dbg && !permit;
    assign bus.lock_vec = lock;
    assign bus.deny_cnt = deny;
endmodule

// File: tb/tb_locked_regbank_arbiter.sv
// Directed bench for locked_regbank_arbiter: vector table of single writes,
// plus read-during-write, round-robin, out-of-range/saturation and reset cases.
module tb_locked_regbank_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    locked_regbank_arbiter_if #(.NREGS(4), .AW(2), .DW(16)) ia ();
    locked_regbank_arbiter_if #(.NREGS(3), .AW(2), .DW(16)) ib ();

    locked_regbank_arbiter #(.NREGS(4), .AW(2), .DW(16)) dut_a (
        .clk(clk), .reset(reset), .bus(ia.slave));
    locked_regbank_arbiter #(.NREGS(3), .AW(2), .DW(16)) dut_b (
        .clk(clk), .reset(reset), .bus(ib.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_dbg;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic        lock;
        logic        trusted;
        logic        dmode;
        logic        exp_err;
        logic [15:0] exp_rd;
        logic [3:0]  exp_lock;
        logic [7:0]  exp_deny;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One write on DUT A, called at a negedge; returns err and ack latency (-1 on timeout).
    task automatic applyStimulus(input vec_t v, output logic err, output int lat);
        ia.trusted    = v.trusted;
        ia.debug_mode = v.dmode;
        if (v.is_dbg) begin
            ia.dbg_req = 1'b1; ia.dbg_addr = v.addr; ia.dbg_wdata = v.wdata;
        end else begin
            ia.host_req = 1'b1; ia.host_addr = v.addr; ia.host_wdata = v.wdata;
            ia.host_lock = v.lock;
        end
        lat = -1;
        err = 1'bx;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if ((v.is_dbg ? ia.dbg_ack : ia.host_ack) === 1'b1) begin
                lat = c;
                err = v.is_dbg ? ia.dbg_err : ia.host_err;
                break;
            end
        end
        ia.host_req = 1'b0;
        ia.dbg_req  = 1'b0;
    endtask

    task automatic hostWriteB(input logic [1:0] addr, input logic [15:0] wdata,
                              input logic lk, output logic err, output int lat);
        ib.host_req = 1'b1; ib.host_addr = addr; ib.host_wdata = wdata; ib.host_lock = lk;
        lat = -1;
        err = 1'bx;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ib.host_ack === 1'b1) begin
                lat = c;
                err = ib.host_err;
                break;
            end
        end
        ib.host_req = 1'b0;
    endtask

    initial begin
        logic err;
        int   lat;
        int   n_acks;
        logic who [4];
        int   when [4];
        logic errs [4];

        checks = 0;
        failures = 0;
        vecs[0] = '{1'b0, 2'd1, 16'hA5A5, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA5A5, 4'b0000, 8'd0};
        vecs[1] = '{1'b0, 2'd2, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 4'b0100, 8'd0};
        vecs[2] = '{1'b0, 2'd2, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 4'b0100, 8'd1};
        vecs[3] = '{1'b1, 2'd2, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 16'hBEEF, 4'b0100, 8'd1};
        vecs[4] = '{1'b1, 2'd2, 16'h0BAD, 1'b0, 1'b0, 1'b1, 1'b1, 16'hBEEF, 4'b0100, 8'd2};
        vecs[5] = '{1'b1, 2'd0, 16'hCAFE, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'b0100, 8'd3};
        vecs[6] = '{1'b0, 2'd0, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0, 16'h5555, 4'b0101, 8'd3};
        vecs[7] = '{1'b1, 2'd0, 16'h7777, 1'b0, 1'b1, 1'b1, 1'b0, 16'h7777, 4'b0101, 8'd3};
        vecs[8] = '{1'b0, 2'd3, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 4'b0101, 8'd3};
        vecs[9] = '{1'b0, 2'd1, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b0, 16'h9999, 4'b0101, 8'd3};

        ia.host_req = 1'b0; ia.host_addr = '0; ia.host_wdata = '0; ia.host_lock = 1'b0;
        ia.dbg_req = 1'b0; ia.dbg_addr = '0; ia.dbg_wdata = '0;
        ia.trusted = 1'b0; ia.debug_mode = 1'b0; ia.rd_addr = '0;
        ib.host_req = 1'b0; ib.host_addr = '0; ib.host_wdata = '0; ib.host_lock = 1'b0;
        ib.dbg_req = 1'b0; ib.dbg_addr = '0; ib.dbg_wdata = '0;
        ib.trusted = 1'b0; ib.debug_mode = 1'b0; ib.rd_addr = '0;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_lock_vec", 32'(ia.lock_vec), 32'h0);
        checkOutput("reset_deny_cnt", 32'(ia.deny_cnt), 32'h0);
        checkOutput("reset_rd_data", 32'(ia.rd_data), 32'h0);
        checkOutput("reset_acks", 32'({ia.host_ack, ia.host_err, ia.dbg_ack, ia.dbg_err}), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], err, lat);
            checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
            checkOutput($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            ia.rd_addr = vecs[i].addr;
            repeat (2) @(negedge clk);
            checkOutput($sformatf("v%0d_rd_data", i), 32'(ia.rd_data), 32'(vecs[i].exp_rd));
            checkOutput($sformatf("v%0d_lock_vec", i), 32'(ia.lock_vec), 32'(vecs[i].exp_lock));
            checkOutput($sformatf("v%0d_deny_cnt", i), 32'(ia.deny_cnt), 32'(vecs[i].exp_deny));
        end

        // Read of the register being written: old value, then new one cycle later.
        ia.rd_addr = 2'd1;
        @(negedge clk);
        applyStimulus('{1'b0, 2'd1, 16'h1357, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1357, 4'b0101, 8'd3}, err, lat);
        checkOutput("rdw_latency", 32'(lat), 32'd2);
        @(negedge clk);
        checkOutput("rdw_old", 32'(ia.rd_data), 32'h9999);
        @(negedge clk);
        checkOutput("rdw_new", 32'(ia.rd_data), 32'h1357);

        // NREGS=3 instance: address 3 is out of range; deny count saturates.
        hostWriteB(2'd3, 16'hDEAD, 1'b0, err, lat);
        checkOutput("b_oor_latency", 32'(lat), 32'd2);
        checkOutput("b_oor_err", 32'(err), 32'd1);
        ib.rd_addr = 2'd3;
        repeat (2) @(negedge clk);
        checkOutput("b_oor_rd", 32'(ib.rd_data), 32'h0);
        checkOutput("b_oor_deny", 32'(ib.deny_cnt), 32'd1);
        checkOutput("b_oor_lock", 32'(ib.lock_vec), 32'h0);
        for (int i = 0; i < 255; i++) begin
            hostWriteB(2'd3, 16'h0F0F, 1'b1, err, lat);
        end
        @(negedge clk);
        checkOutput("b_deny_sat", 32'(ib.deny_cnt), 32'd255);
        checkOutput("b_last_err", 32'(err), 32'd1);
        hostWriteB(2'd2, 16'h4242, 1'b1, err, lat);
        checkOutput("b_ok_err", 32'(err), 32'd0);
        ib.rd_addr = 2'd2;
        repeat (2) @(negedge clk);
        checkOutput("b_ok_rd", 32'(ib.rd_data), 32'h4242);
        checkOutput("b_ok_lock", 32'(ib.lock_vec), 32'b100);
        checkOutput("b_deny_hold", 32'(ib.deny_cnt), 32'd255);

        // Reset while a host lock-write sits in CHECK.
        ia.host_req = 1'b1; ia.host_addr = 2'd1; ia.host_wdata = 16'h2222; ia.host_lock = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        ia.host_req = 1'b0;
        @(negedge clk);
        checkOutput("rst_no_ack1", 32'(ia.host_ack), 32'd0);
        checkOutput("rst_lock_vec", 32'(ia.lock_vec), 32'h0);
        checkOutput("rst_deny", 32'(ia.deny_cnt), 32'h0);
        @(negedge clk);
        checkOutput("rst_no_ack2", 32'(ia.host_ack), 32'd0);

        // Both requesters held high from the first cycle after reset.
        reset = 1'b0;
        ia.trusted = 1'b1; ia.debug_mode = 1'b1;
        ia.host_req = 1'b1; ia.host_addr = 2'd0; ia.host_wdata = 16'h1111; ia.host_lock = 1'b0;
        ia.dbg_req = 1'b1; ia.dbg_addr = 2'd1; ia.dbg_wdata = 16'h2222;
        n_acks = 0;
        for (int c = 1; c <= 20 && n_acks < 4; c++) begin
            @(negedge clk);
            if (ia.host_ack === 1'b1 || ia.dbg_ack === 1'b1) begin
                who[n_acks]  = ia.dbg_ack;
                when[n_acks] = c;
                errs[n_acks] = ia.host_err | ia.dbg_err;
                n_acks++;
            end
        end
        ia.host_req = 1'b0;
        ia.dbg_req  = 1'b0;
        checkOutput("rr_ack_count", 32'(n_acks), 32'd4);
        for (int k = 0; k < n_acks; k++) begin
            checkOutput($sformatf("rr%0d_is_dbg", k), 32'(who[k]), 32'(k % 2));
            checkOutput($sformatf("rr%0d_cycle", k), 32'(when[k]), 32'(2 + 3 * k));
            checkOutput($sformatf("rr%0d_err", k), 32'(errs[k]), 32'd0);
        end
        ia.rd_addr = 2'd2;
        repeat (2) @(negedge clk);
        checkOutput("post_rst_rd2", 32'(ia.rd_data), 32'h0);
        checkOutput("post_rst_lock", 32'(ia.lock_vec), 32'h0);
        ia.rd_addr = 2'd0;
        @(negedge clk);
        checkOutput("rr_rd0", 32'(ia.rd_data), 32'h1111);
        ia.rd_addr = 2'd1;
        @(negedge clk);
        checkOutput("rr_rd1", 32'(ia.rd_data), 32'h2222);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/locked_regbank_arbiter.md
Name: locked_regbank_arbiter

Overview:
Access controller for a bank of lockable 16-bit configuration registers shared by two requesters: the host port and the debug port. It arbitrates round-robin between them and sequences each write through a 3-state handshake. It enforces the per-register sticky lock rule: host writes are blocked once a register is locked, and debug writes are allowed only when both trusted and debug_mode are high. It sits between the bus-side requesters and the register storage, and exports lock state and a denial counter to security monitoring.

Parameters:
NREGS, 4, number of registers in the bank (2..16)
AW, 2, address width; addr >= NREGS is out of range
DW, 16, data width

Ports:
Clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
host_req  input  1  host write request; held until host_ack
host_addr  input  AW  host target register
host_wdata  input  DW  host write data
host_lock  input  1  with host_req: set lock of target after the write
host_ack  output  1  one-cycle completion pulse to host
host_err  output  1  one-cycle denial pulse, coincident with host_ack
dbg_req  input  1  debug write request; held until dbg_ack
dbg_addr  input  AW  debug target register
dbg_wdata  input  DW  debug write data
dbg_ack  output  1  one-cycle completion pulse to debug
dbg_err  output  1  one-cycle denial pulse, coincident with dbg_ack
trusted  input  1  debug authorisation
debug_mode  input  1  debug mode enable
rd_addr  input  AW  read address
rd_data  output  DW  registered read data, 1-cycle latency; 0 if out of range
lock_vec  output  NREGS  current lock bit per register
deny_cnt  output  8  saturating count of denied requests

Behaviour:
- Reset values: all registers 0, lock_vec 0, deny_cnt 0, rd_data 0, all ack/err 0, FSM IDLE, last_grant = debug (so host wins first tie).
- FSM states are IDLE, CHECK, RESP.
- IDLE: if neither req is high, stay in IDLE. If one is high, grant it. If both are high, grant the requester not equal to last_grant. Latch the granter's addr, wdata and host_lock (0 for debug), update last_grant, then go to CHECK.
- CHECK: sample trusted and debug_mode, then compute permit:
  - host: addr in range AND lock[addr]==0.
  - debug: addr in range AND trusted AND debug_mode; the lock bit is ignored.
  - Then go to RESP.
- RESP: the granted ack is high for exactly this cycle. err is high in the same cycle iff permit==0.
  - If permit: reg[addr] <= wdata at the end of RESP. If latched host_lock, also set lock[addr].
  - If not permit: the register and lock are unchanged, and deny_cnt increments, saturating at 255.
  - Then go to IDLE.
- Latency: req sampled at edge N produces ack high during cycle N+2, and data is visible in storage from cycle N+3.
- Handshake: a requester drops req at the edge where it samples ack, so IDLE at N+3 does not re-grant it. A req dropped before ack is a protocol violation; the transaction still completes on latched values.
- Lock bits are sticky. Only reset clears them, and the debug port can never set or clear a lock.
- trusted/debug_mode changes after CHECK do not affect an in-flight transaction.
- rd_data <= reg[rd_addr] every cycle. A read of the address being written in RESP returns the old value in the next cycle and the new value one cycle later.
- Reset asserted in any state: the FSM returns to IDLE and no ack/err is issued for the in-flight request. All state returns to its reset value.

Test Plan:
- Host writes 16'hA5A5 to addr 1 with host_lock=0 -> host_ack pulses at N+2, host_err=0, rd_data(addr 1)=16'hA5A5, lock_vec=4'b0000.
- Host writes 16'h1234 to addr 2 with host_lock=1, then writes 16'hFFFF to addr 2 -> first completes and lock_vec=4'b0100; second gets host_ack+host_err, reg stays 16'h1234, deny_cnt=1.
- Debug writes 16'hBEEF to locked addr 2 with trusted=1, debug_mode=1 -> dbg_ack, no err, reg=16'hBEEF, lock_vec unchanged. Repeat with trusted=0 -> dbg_err, reg stays 16'hBEEF, deny_cnt increments.
- host_req and dbg_req asserted together, continuously re-requesting after each ack -> grant order is host, debug, host, debug, and each ack arrives 3 cycles apart.
- With NREGS=3, host writes addr 3 -> host_err, no storage change. Force 256 denials -> deny_cnt holds at 255.
- Assert reset during CHECK of a host lock-write -> no host_ack, lock_vec=0, all regs 0, FSM accepts a new request the cycle after reset deasserts.
